// File: rtl/scr1_trace_pkg.sv
// Shared types and constants for the IMEM fetch trace capture block.
//
// Contents:
//   type_scr1_trace_resp_e  - IMEM response codes (11 is handled as an error)
//   type_scr1_trace_rec_s   - one trace record {addr, instr, err, match}
//   type_scr1_trace_fsm_e   - output stage states
//   SCR1_TRACE_DROP_CNT_W   - width of the dropped-record counter
package scr1_trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RDY  = 2'b01,
        ER   = 2'b10
    } type_scr1_trace_resp_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        logic        match;
    } type_scr1_trace_rec_s;

    typedef enum logic {
        TRC_FSM_IDLE = 1'b0,
        TRC_FSM_HOLD = 1'b1
    } type_scr1_trace_fsm_e;

    localparam int SCR1_TRACE_DROP_CNT_W = 16;

endpackage : scr1_trace_pkg

// File: rtl/scr1_trace_addr_fifo.sv
// Small address FIFO holding the fetch addresses of outstanding requests.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push      - write wdata; ignored when full unless a pop happens this cycle
//   pop       - remove the head; ignored when empty (no bypass of a same-cycle push)
//   wdata     - data to push
//   rdata     - current head (meaningful only when !empty)
//   empty     - no entries
//   full      - DEPTH entries
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits are equal.
module scr1_trace_addr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_eff;
    logic             push_eff;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on an empty FIFO is a no-op; a push into a full FIFO only
    // succeeds when the head is leaving in the same cycle.
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);

    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop_eff)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule : scr1_trace_addr_fifo

// File: rtl/scr1_imem_trace_capture.sv
// Pairs accepted IMEM fetch requests with their responses and emits one trace
// record per response on a valid/ready stream.
//
// Configuration macro: SCR1_TRACE_CMD_MATCH_EN
//   defined   - instruction pattern comparator and match_cnt are built
//   undefined - trc_match and match_cnt are constant 0, match_mask and
//               match_pattern are ignored
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   imem_req/_ack     - request handshake; a fire pushes imem_addr
//   imem_addr         - fetch address
//   imem_rdata        - fetch data, valid with a non-idle imem_resp
//   imem_resp         - 00 idle, 01 ready, 10/11 error; non-idle pops an address
//   match_mask/pattern- instruction compare (quasi-static)
//   trc_vld/trc_rdy   - record stream handshake
//   trc_addr/instr/err/match - record fields
//   match_cnt         - matched records loaded into the output (wraps)
//   drop_cnt          - records lost to back-pressure (saturates)
//   fifo_ovf          - sticky: accepted request lost on full address FIFO
//   orphan_resp       - sticky: response with no outstanding address
//
// Stream handshake: a record transfers on a cycle where trc_vld and trc_rdy
// are both high; while trc_vld is high and trc_rdy low the record fields are
// held stable, and any record arriving then is dropped and counted.
module scr1_imem_trace_capture
    import scr1_trace_pkg::*;
#(
    parameter int ADDR_FIFO_DEPTH = 4,
    parameter int CNT_W           = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             imem_req,
    input  logic                             imem_req_ack,
    input  logic [31:0]                      imem_addr,
    input  logic [31:0]                      imem_rdata,
    input  logic [1:0]                       imem_resp,
    input  logic [31:0]                      match_mask,
    input  logic [31:0]                      match_pattern,
    output logic                             trc_vld,
    input  logic                             trc_rdy,
    output logic [31:0]                      trc_addr,
    output logic [31:0]                      trc_instr,
    output logic                             trc_err,
    output logic                             trc_match,
    output logic [CNT_W-1:0]                 match_cnt,
    output logic [SCR1_TRACE_DROP_CNT_W-1:0] drop_cnt,
    output logic                             fifo_ovf,
    output logic                             orphan_resp
);

    logic                  push;
    logic                  resp_vld;
    logic [31:0]           head_addr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  new_err;
    logic                  new_match;
    type_scr1_trace_rec_s  new_rec;
    type_scr1_trace_rec_s  rec_q;
    type_scr1_trace_fsm_e  state_q;
    type_scr1_trace_fsm_e  state_d;
    logic                  load;
    logic                  drop;
    logic [SCR1_TRACE_DROP_CNT_W-1:0] drop_cnt_q;

    assign push     = imem_req & imem_req_ack;
    assign resp_vld = (imem_resp != IDLE);

    scr1_trace_addr_fifo #(
        .DEPTH (ADDR_FIFO_DEPTH),
        .WIDTH (32)
    ) i_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (resp_vld),
        .wdata (imem_addr),
        .rdata (head_addr),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Both 10 and 11 are error responses.
    assign new_err = imem_resp[1];

`ifdef SCR1_TRACE_CMD_MATCH_EN
    logic [CNT_W-1:0] match_cnt_q;

    // Only a clean (RDY) response can match; error data is never compared.
    assign new_match = (imem_resp == RDY)
                    && ((imem_rdata & match_mask) == (match_pattern & match_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q <= '0;
        end else if (load && new_rec.match) begin
            match_cnt_q <= match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign match_cnt = match_cnt_q;
`else
    logic unused_match_cfg;
    assign unused_match_cfg = ^{match_mask, match_pattern};
    assign new_match        = 1'b0;
    assign match_cnt        = '0;
`endif

    // An orphan response still produces a record, with a zero address.
    always_comb begin
        new_rec       = '0;
        new_rec.addr  = fifo_empty ? 32'h0 : head_addr;
        new_rec.instr = new_err ? 32'h0 : imem_rdata;
        new_rec.err   = new_err;
        new_rec.match = new_match;
    end

    // Output stage: IDLE has nothing to offer, HOLD presents rec_q.
    always_ff @(posedge clk) begin
        if (rst) state_q <= TRC_FSM_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            TRC_FSM_IDLE: begin
                if (resp_vld) begin
                    load    = 1'b1;
                    state_d = TRC_FSM_HOLD;
                end
            end
            TRC_FSM_HOLD: begin
                if (trc_rdy) begin
                    if (resp_vld) load = 1'b1;
                    else          state_d = TRC_FSM_IDLE;
                end else if (resp_vld) begin
                    drop = 1'b1;
                end
            end
            default: state_d = TRC_FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q <= '0;
        end else if (load) begin
            rec_q <= new_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {SCR1_TRACE_DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + {{(SCR1_TRACE_DROP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Overflow only when the full FIFO is not being popped in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_ovf    <= 1'b0;
            orphan_resp <= 1'b0;
        end else begin
            if (push && fifo_full && !resp_vld) fifo_ovf    <= 1'b1;
            if (resp_vld && fifo_empty)         orphan_resp <= 1'b1;
        end
    end

    assign trc_vld   = (state_q == TRC_FSM_HOLD);
    assign trc_addr  = rec_q.addr;
    assign trc_instr = rec_q.instr;
    assign trc_err   = rec_q.err;
    assign trc_match = rec_q.match;
    assign drop_cnt  = drop_cnt_q;

endmodule : scr1_imem_trace_capture

// File: tb/tb_scr1_imem_trace_capture.sv
module tb_scr1_imem_trace_capture;

`ifdef SCR1_TRACE_CMD_MATCH_EN
    localparam logic MEN = 1'b1;
`else
    localparam logic MEN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_req_ack;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic [31:0] match_mask;
    logic [31:0] match_pattern;
    logic        trc_vld;
    logic        trc_rdy;
    logic [31:0] trc_addr;
    logic [31:0] trc_instr;
    logic        trc_err;
    logic        trc_match;
    logic [31:0] match_cnt;
    logic [15:0] drop_cnt;
    logic        fifo_ovf;
    logic        orphan_resp;

    int errors = 0;
    int checks = 0;

    scr1_imem_trace_capture #(
        .ADDR_FIFO_DEPTH (4),
        .CNT_W           (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_req_ack  (imem_req_ack),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_resp     (imem_resp),
        .match_mask    (match_mask),
        .match_pattern (match_pattern),
        .trc_vld       (trc_vld),
        .trc_rdy       (trc_rdy),
        .trc_addr      (trc_addr),
        .trc_instr     (trc_instr),
        .trc_err       (trc_err),
        .trc_match     (trc_match),
        .match_cnt     (match_cnt),
        .drop_cnt      (drop_cnt),
        .fifo_ovf      (fifo_ovf),
        .orphan_resp   (orphan_resp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock edge, then settle
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        imem_req     = 1'b0;
        imem_req_ack = 1'b0;
        imem_addr    = 32'h0;
        imem_rdata   = 32'h0;
        imem_resp    = 2'b00;
    endtask

    task automatic do_reset();
        idle_in();
        trc_rdy = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // one accepted request, no response
    task automatic req(input logic [31:0] a);
        imem_req = 1'b1; imem_req_ack = 1'b1; imem_addr = a;
        cyc();
        imem_req = 1'b0; imem_req_ack = 1'b0;
    endtask

    // one response cycle
    task automatic rsp(input logic [1:0] r, input logic [31:0] d);
        imem_resp = r; imem_rdata = d;
        cyc();
        imem_resp = 2'b00; imem_rdata = 32'h0;
    endtask

    initial begin
        match_mask    = 32'hFE00707F;
        match_pattern = 32'h00007033;
        rst           = 1'b1;
        do_reset();

        // reset state
        chk("rst_vld",    {31'b0, trc_vld}, 32'h0);
        chk("rst_addr",   trc_addr, 32'h0);
        chk("rst_instr",  trc_instr, 32'h0);
        chk("rst_flags",  {28'b0, trc_err, trc_match, fifo_ovf, orphan_resp}, 32'h0);
        chk("rst_mcnt",   match_cnt, 32'h0);
        chk("rst_dcnt",   {16'b0, drop_cnt}, 32'h0);

        // back-to-back requests, then responses one per cycle
        req(32'h200); req(32'h204); req(32'h208);
        imem_resp = 2'b01; imem_rdata = 32'h0020F033;
        cyc();
        chk("b2b0_vld",   {31'b0, trc_vld}, 32'h1);
        chk("b2b0_addr",  trc_addr, 32'h200);
        chk("b2b0_instr", trc_instr, 32'h0020F033);
        chk("b2b0_err",   {31'b0, trc_err}, 32'h0);
        chk("and_match",  {31'b0, trc_match}, {31'b0, MEN});
        chk("and_mcnt",   match_cnt, {31'b0, MEN});
        imem_rdata = 32'h00000013;
        cyc();
        chk("b2b1_addr",  trc_addr, 32'h204);
        chk("b2b1_instr", trc_instr, 32'h13);
        chk("nop_match",  {31'b0, trc_match}, 32'h0);
        cyc();
        chk("b2b2_vld",   {31'b0, trc_vld}, 32'h1);
        chk("b2b2_addr",  trc_addr, 32'h208);
        imem_resp = 2'b00; imem_rdata = 32'h0;
        cyc();
        chk("b2b_end_vld", {31'b0, trc_vld}, 32'h0);
        chk("b2b_mcnt",   match_cnt, {31'b0, MEN});

        // error response with matching data never matches
        req(32'h300);
        rsp(2'b10, 32'h0020F033);
        chk("er_addr",    trc_addr, 32'h300);
        chk("er_err",     {31'b0, trc_err}, 32'h1);
        chk("er_instr",   trc_instr, 32'h0);
        chk("er_match",   {31'b0, trc_match}, 32'h0);
        chk("er_mcnt",    match_cnt, {31'b0, MEN});
        req(32'h304);
        rsp(2'b11, 32'h0020F033);
        chk("r11_err",    {31'b0, trc_err}, 32'h1);
        chk("r11_addr",   trc_addr, 32'h304);
        chk("no_orphan",  {31'b0, orphan_resp}, 32'h0);
        chk("no_ovf",     {31'b0, fifo_ovf}, 32'h0);

        // FIFO overflow: 4 fill it, 5th is lost
        do_reset();
        for (int i = 0; i < 4; i++) req(32'h400 + 32'(i * 4));
        chk("fill_ovf",   {31'b0, fifo_ovf}, 32'h0);
        req(32'h410);
        chk("ovf_set",    {31'b0, fifo_ovf}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            rsp(2'b01, 32'h0);
            chk("ovf_drain", trc_addr, 32'h400 + 32'(i * 4));
        end
        chk("ovf_no_orphan", {31'b0, orphan_resp}, 32'h0);
        rsp(2'b01, 32'h0);
        chk("ovf_orphan", {31'b0, orphan_resp}, 32'h1);
        chk("ovf_orph_addr", trc_addr, 32'h0);

        // full FIFO with coincident push and pop: no overflow, order kept
        do_reset();
        for (int i = 0; i < 4; i++) req(32'h400 + 32'(i * 4));
        imem_req = 1'b1; imem_req_ack = 1'b1; imem_addr = 32'h410;
        imem_resp = 2'b01;
        cyc();
        imem_req = 1'b0; imem_req_ack = 1'b0;
        chk("pp_ovf",     {31'b0, fifo_ovf}, 32'h0);
        chk("pp_addr0",   trc_addr, 32'h400);
        for (int i = 1; i < 5; i++) begin
            cyc();
            chk("pp_order", trc_addr, 32'h400 + 32'(i * 4));
        end
        imem_resp = 2'b00;
        chk("pp_no_orphan", {31'b0, orphan_resp}, 32'h0);

        // back-pressure: second record dropped, first held
        do_reset();
        req(32'h500); req(32'h504);
        trc_rdy = 1'b0;
        rsp(2'b01, 32'hA);
        chk("bp_vld",     {31'b0, trc_vld}, 32'h1);
        chk("bp_addr",    trc_addr, 32'h500);
        rsp(2'b01, 32'hB);
        chk("bp_hold_addr",  trc_addr, 32'h500);
        chk("bp_hold_instr", trc_instr, 32'hA);
        chk("bp_drop",    {16'b0, drop_cnt}, 32'h1);
        cyc();
        chk("bp_still",   trc_instr, 32'hA);
        trc_rdy = 1'b1;
        #1;
        chk("bp_rel_vld", {31'b0, trc_vld}, 32'h1);
        chk("bp_rel_addr", trc_addr, 32'h500);
        cyc();
        chk("bp_done_vld", {31'b0, trc_vld}, 32'h0);
        chk("bp_drop_final", {16'b0, drop_cnt}, 32'h1);

        // orphan, then reset with outstanding requests
        do_reset();
        rsp(2'b01, 32'h55);
        chk("orph_flag",  {31'b0, orphan_resp}, 32'h1);
        chk("orph_addr",  trc_addr, 32'h0);
        chk("orph_vld",   {31'b0, trc_vld}, 32'h1);
        req(32'h600); req(32'h604);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_vld",  {31'b0, trc_vld}, 32'h0);
        chk("mid_rst_addr", trc_addr, 32'h0);
        chk("mid_rst_instr", trc_instr, 32'h0);
        chk("mid_rst_flags", {30'b0, fifo_ovf, orphan_resp}, 32'h0);
        chk("mid_rst_cnt",  match_cnt | {16'b0, drop_cnt}, 32'h0);
        rsp(2'b01, 32'h77);
        chk("post_rst_orphan", {31'b0, orphan_resp}, 32'h1);
        chk("post_rst_addr",   trc_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scr1_imem_trace_capture

// File: doc/scr1_imem_trace_capture.md
# scr1_imem_trace_capture

Pairs every instruction-memory fetch request accepted on the core side of the IMEM AHB bridge with its response, and emits one trace record (fetch address, instruction word, error flag, pattern-match flag) per response on a valid/ready stream. It sits between the core/IMEM bridge interface and the command-detection/logging stage, which consumes its records. It counts pattern-matched instructions, for example an AND opcode, without any hierarchical peeking.

## Interface
Parameters:
- ADDR_FIFO_DEPTH, 4: number of outstanding fetch addresses tracked; power of two, ≥2.
- CNT_W, 32: width of match_cnt.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  in  1  core fetch request.
- imem_req_ack  in  1  bridge accepts the request.
- imem_addr  in  32  fetch address, valid with imem_req.
- imem_rdata  in  32  fetch data, valid when imem_resp ≠ 00.
- imem_resp  in  2  response code: 00 idle, 01 ready, 10 error, 11 treated as error.
- match_mask  in  32  instruction compare mask; quasi-static.
- match_pattern  in  32  instruction compare value; quasi-static.
- trc_vld  out  1  trace record valid.
- trc_rdy  in  1  consumer ready.
- trc_addr  out  32  fetch address of the record.
- trc_instr  out  32  instruction word; 0 for an error response.
- trc_err  out  1  response was error.
- trc_match  out  1  instruction matched the pattern.
- match_cnt  out  CNT_W  count of matched records produced; wraps.
- drop_cnt  out  16  count of records lost to back-pressure; saturates at 0xFFFF.
- fifo_ovf  out  1  sticky: an accepted request was lost because the address FIFO was full.
- orphan_resp  out  1  sticky: a response arrived with no outstanding address.

## Operation
- Push: imem_req & imem_req_ack pushes imem_addr into the address FIFO.
- Pop: imem_resp ≠ 00 pops the FIFO head and forms a record from {head, imem_rdata, err}.
- Push and pop may occur in the same cycle:
  - When full: the pop frees the slot and the push succeeds.
  - When empty: the push does not bypass; the pop sees an empty FIFO.
- Full with push and no pop: the address is discarded and fifo_ovf is set.
- Empty with a response: orphan_resp is set and a record is still emitted with trc_addr = 0.
- Match: resp = 01 and (imem_rdata & match_mask) == (match_pattern & match_mask). An error response never matches.
- Output stage FSM:
  - IDLE (trc_vld = 0): a new record is loaded and the FSM goes to HOLD.
  - HOLD (trc_vld = 1):
    - Handshake (trc_rdy) with no new record: go to IDLE.
    - Handshake with a new record: load it and stay in HOLD.
    - No handshake with a new record: the new record is dropped, drop_cnt increments, and the held record is unchanged.
- match_cnt increments when a matched record is loaded into the output register, not when it is consumed.

## Timing
- Reset values:
  - trc_vld = 0; trc_addr, trc_instr, trc_err, trc_match = 0.
  - match_cnt = 0, drop_cnt = 0, fifo_ovf = 0, orphan_resp = 0.
  - FIFO empty; FSM in IDLE.
- Latency: a response in cycle N gives trc_vld = 1 with its record in cycle N+1.
- Throughput: one record per cycle while trc_rdy stays high.
- Record fields are stable while trc_vld & !trc_rdy.
- Reset asserted mid-operation flushes all outstanding addresses and any held record. Responses to requests issued before reset then appear as orphans, which is the required behaviour.
- Sticky flags clear only on rst.

## Configuration
- SCR1_TRACE_CMD_MATCH_EN defined:
  - Match comparator and match_cnt are built.
  - trc_match and match_cnt behave as described above.
- SCR1_TRACE_CMD_MATCH_EN undefined:
  - trc_match is tied to 0 and match_cnt is tied to 0.
  - match_mask and match_pattern are unused.
  - No match logic is synthesized.

## Structure
- Package scr1_trace_pkg holds:
  - enum type_scr1_trace_resp_e (IDLE = 2'b00, RDY = 2'b01, ER = 2'b10).
  - struct type_scr1_trace_rec_s {addr, instr, err, match}.
  - localparam SCR1_TRACE_DROP_CNT_W = 16.
- Sub-module scr1_trace_addr_fifo:
  - Parameterised depth and width.
  - Ports: push, pop, wdata, rdata, empty, full.
  - Pointers one bit wider than the index, for full/empty detection across wrap-around.
  - Simultaneous push+pop when full is permitted.

## Test plan
- Back-to-back requests: 3 accepted requests at 0x200, 0x204, 0x208, then 3 RDY responses with data 0x0020F033 and two NOPs. Required: 3 records in order, addresses matching, trc_err = 0, each 1 cycle after its response.
- AND match: mask = 0xFE00707F, pattern = 0x00007033, response data 0x0020F033. Required: trc_match = 1 and match_cnt = 1. An ER response with the same data gives trc_match = 0 with match_cnt unchanged.
- FIFO boundary:
  - 4 requests with no response, then a 5th with no pop: fifo_ovf = 1.
  - Repeat from reset with the 5th request coincident with a response: no overflow, and record order is preserved.
- Back-pressure: trc_rdy = 0 with 2 responses in consecutive cycles. Required: first record held, drop_cnt = 1. Raising trc_rdy then yields exactly the first record.
- Orphan and reset: a response with the FIFO empty gives orphan_resp = 1 and trc_addr = 0. Asserting rst with 2 requests outstanding clears all outputs, and the next response is flagged orphan.
